// File: rtl/cordic_iter_ctrl_pkg.sv
// rtl/cordic_iter_ctrl_pkg.sv - shared types, defaults and atan table for the CORDIC iteration controller
// Purpose: FSM state encoding, WIDTH/ITER defaults and the atan(2^-i) table
//          in 0x10000 = 360 deg units, rounded to nearest.
package cordic_iter_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ITER_DEF  = 16;
  localparam int LUT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] ATAN_LUT [LUT_DEPTH] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
    16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005,
    16'h0003, 16'h0001, 16'h0001, 16'h0000
  };

  // Beyond 2^-15 the angle rounds to zero at this resolution.
  function automatic logic [15:0] atan_entry(input int unsigned idx);
    if (idx < LUT_DEPTH) return ATAN_LUT[idx[3:0]];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iteration controller for a rotation-mode CORDIC
// Purpose: holds x/y/angle state, sequences ITER micro-rotations through an
//          external combinational rotation ALU, and registers the results.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      job request, sampled only in IDLE
//   x_in, y_in, target_in      job operands (target: 0x10000 = 360 deg)
//   x_init, y_init             current x/y registers to the ALU
//   x_shift, y_shift           x/y registers arithmetically shifted by i
//   angle, target_angle        accumulated angle, latched target
//   delta_angle                atan table entry for the current step
//   x_alu, y_alu, angle_alu    rotated values returned by the ALU
//   busy, done                 job in flight, one-cycle result strobe
//   x_res, y_res, angle_res    final results, held until the next done
module cordic_iter_ctrl
  import cordic_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = ITER_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] target_in,
  output logic [WIDTH-1:0] x_init,
  output logic [WIDTH-1:0] y_init,
  output logic [WIDTH-1:0] x_shift,
  output logic [WIDTH-1:0] y_shift,
  output logic [WIDTH-1:0] angle,
  output logic [WIDTH-1:0] target_angle,
  output logic [WIDTH-1:0] delta_angle,
  input  logic [WIDTH-1:0] x_alu,
  input  logic [WIDTH-1:0] y_alu,
  input  logic [WIDTH-1:0] angle_alu,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_res,
  output logic [WIDTH-1:0] y_res,
  output logic [WIDTH-1:0] angle_res
);

  localparam int IW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [IW-1:0]    i_q, i_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, angle_q, angle_d, target_q, target_d;
  logic [WIDTH-1:0] x_res_q, x_res_d, y_res_q, y_res_d, angle_res_q, angle_res_d;
  logic             done_q, done_d;
  logic [WIDTH+15:0] lut_ext;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    x_d         = x_q;
    y_d         = y_q;
    angle_d     = angle_q;
    target_d    = target_q;
    x_res_d     = x_res_q;
    y_res_d     = y_res_q;
    angle_res_d = angle_res_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d      = x_in;
          y_d      = y_in;
          target_d = target_in;
          angle_d  = '0;
          i_d      = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d     = x_alu;
        y_d     = y_alu;
        angle_d = angle_alu;
        i_d     = i_q + 1'b1;
        if (i_q == IW'(ITER - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // x/y/angle already hold the result of the last micro-rotation.
        x_res_d     = x_q;
        y_res_d     = y_q;
        angle_res_d = angle_q;
        done_d      = 1'b1;
        i_d         = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      angle_q     <= '0;
      target_q    <= '0;
      x_res_q     <= '0;
      y_res_q     <= '0;
      angle_res_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      x_q         <= x_d;
      y_q         <= y_d;
      angle_q     <= angle_d;
      target_q    <= target_d;
      x_res_q     <= x_res_d;
      y_res_q     <= y_res_d;
      angle_res_q <= angle_res_d;
      done_q      <= done_d;
    end
  end

  // Table entries are 16-bit; zero-extend and cut to WIDTH.
  assign lut_ext = {{WIDTH{1'b0}}, atan_entry(32'(i_q))};

  assign x_init       = x_q;
  assign y_init       = y_q;
  assign x_shift      = $signed(x_q) >>> i_q;
  assign y_shift      = $signed(y_q) >>> i_q;
  assign angle        = angle_q;
  assign target_angle = target_q;
  // Only meaningful while rotating; held at zero otherwise so idle outputs are clean.
  assign delta_angle  = (state_q == ST_RUN) ? lut_ext[WIDTH-1:0] : '0;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign x_res        = x_res_q;
  assign y_res        = y_res_q;
  assign angle_res    = angle_res_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb/tb_cordic_iter_ctrl.sv - self-checking bench for cordic_iter_ctrl with a rotation ALU model
module tb_cordic_iter_ctrl;

  localparam int WIDTH = 16;
  localparam int ITER  = 16;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] x_in, y_in, target_in;
  logic [15:0] x_init, y_init, x_shift, y_shift, angle, target_angle, delta_angle;
  logic [15:0] x_alu, y_alu, angle_alu;
  logic        busy, done;
  logic [15:0] x_res, y_res, angle_res;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;

  cordic_iter_ctrl #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_in(x_in), .y_in(y_in), .target_in(target_in),
    .x_init(x_init), .y_init(y_init), .x_shift(x_shift), .y_shift(y_shift),
    .angle(angle), .target_angle(target_angle), .delta_angle(delta_angle),
    .x_alu(x_alu), .y_alu(y_alu), .angle_alu(angle_alu),
    .busy(busy), .done(done),
    .x_res(x_res), .y_res(y_res), .angle_res(angle_res)
  );

  // Rotation ALU stage: together with the controller this forms the cordic_core.
  logic [15:0] resid;
  assign resid = target_angle - angle;
  always_comb begin
    x_alu = x_init;
    y_alu = y_init;
    angle_alu = angle;
    if (!resid[15]) begin
      x_alu = x_init - y_shift;
      y_alu = y_init + x_shift;
      angle_alu = angle + delta_angle;
    end else begin
      x_alu = x_init + y_shift;
      y_alu = y_init - x_shift;
      angle_alu = angle - delta_angle;
    end
  end

  // Reference: atan table from real arithmetic, per-step values from the textbook recurrence.
  logic [15:0] lut [0:ITER-1];
  logic [15:0] mx [0:ITER];
  logic [15:0] my [0:ITER];
  logic [15:0] ma [0:ITER];

  task automatic build_lut();
    real r;
    for (int k = 0; k < ITER; k++) begin
      r = $atan(1.0 / (2.0 ** k)) * 65536.0 / (2.0 * 3.14159265358979);
      lut[k] = 16'($rtoi(r + 0.5));
    end
  endtask

  task automatic model(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] t0);
    logic signed [15:0] x, y, a, xs, ys, z;
    x = x0; y = y0; a = 16'h0;
    mx[0] = x; my[0] = y; ma[0] = a;
    for (int k = 0; k < ITER; k++) begin
      xs = x >>> k;
      ys = y >>> k;
      z = t0 - a;
      if (z >= 0) begin x = x - ys; y = y + xs; a = a + lut[k]; end
      else        begin x = x + ys; y = y - xs; a = a - lut[k]; end
      mx[k+1] = x; my[k+1] = y; ma[k+1] = a;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs, input logic [15:0] exp, input int tol);
    int diff;
    diff = int'($signed(obs)) - int'($signed(exp));
    checks++;
    assert (diff <= tol && diff >= -tol) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_x_init"}, x_init, 16'h0);
    check({tag, "_y_shift"}, y_shift, 16'h0);
    check({tag, "_angle"}, angle, 16'h0);
    check({tag, "_target"}, target_angle, 16'h0);
    check({tag, "_delta"}, delta_angle, 16'h0);
    check({tag, "_busy"}, {15'h0, busy}, 16'h0);
    check({tag, "_done"}, {15'h0, done}, 16'h0);
    check({tag, "_x_res"}, x_res, 16'h0);
    check({tag, "_y_res"}, y_res, 16'h0);
    check({tag, "_angle_res"}, angle_res, 16'h0);
  endtask

  // One job; optional extra start pulse during RUN cycle extra_cyc (ignored by a correct DUT).
  task automatic run_job(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] t0,
                         input int extra_cyc, input bit deep);
    int lat;
    model(x0, y0, t0);
    x_in = x0; y_in = y0; target_in = t0; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (deep && lat < ITER) begin
        check("run_x", x_init, mx[lat]);
        check("run_y", y_init, my[lat]);
        check("run_angle", angle, ma[lat]);
        check("run_xshift", x_shift, 16'($signed(mx[lat]) >>> lat));
        check("run_yshift", y_shift, 16'($signed(my[lat]) >>> lat));
        check("run_delta", delta_angle, lut[lat]);
        check("run_busy", {15'h0, busy}, 16'h1);
      end
      if (lat == ITER) check("done_state_busy", {15'h0, busy}, 16'h1);
      start = (lat == extra_cyc);
      step();
      lat++;
    end
    start = 1'b0;
    check("latency", 16'(lat), 16'(ITER + 1));
    check("x_res", x_res, mx[ITER]);
    check("y_res", y_res, my[ITER]);
    check("angle_res", angle_res, ma[ITER]);
    check("busy_after_done", {15'h0, busy}, 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, t1, t2, w;
    logic [15:0] rx, ry, rt;
    build_lut();
    check("lut0", lut[0], 16'h2000);
    check("lut3", lut[3], 16'h0511);

    // Reset with start asserted: start must be discarded.
    rst_n = 1'b0; start = 1'b1;
    x_in = 16'h1234; y_in = 16'h5678; target_in = 16'h1000;
    step(); step();
    check_idle_zero("reset");
    rst_n = 1'b1; start = 1'b0;
    step();
    check("post_reset_idle", {15'h0, busy}, 16'h0);

    // 45 degrees.
    run_job(16'h4000, 16'h0000, 16'h2000, -1, 1'b1);
    check_near("d45_x", x_res, 16'h4A87, 4);
    check_near("d45_y", y_res, 16'h4A87, 4);
    check_near("d45_a", angle_res, 16'h2000, 2);

    // 30 degrees.
    run_job(16'h4000, 16'h0000, 16'h1555, -1, 1'b1);
    check_near("d30_x", x_res, 16'h5B46, 4);
    check_near("d30_y", y_res, 16'h34B2, 4);

    // Results hold for 100 cycles without a new start.
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (x_res !== mx[ITER] || y_res !== my[ITER] || angle_res !== ma[ITER] || done !== 1'b0) cnt++;
    end
    check("hold_100", 16'(cnt), 16'h0);

    // Extra start in RUN cycle 5 is ignored; no second done.
    run_job(16'h2000, 16'hE000, 16'h0C00, 5, 1'b1);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done === 1'b1) cnt++;
    end
    check("no_queued_done", 16'(cnt), 16'h0);

    // Reset in RUN cycle 8 aborts the job.
    x_in = 16'h3000; y_in = 16'h1000; target_in = 16'h2800; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("pre_abort_busy", {15'h0, busy}, 16'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle_zero("abort");
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    check("abort_no_done", 16'(cnt), 16'h0);

    // Back-to-back with start held high.
    model(16'h1800, 16'h0800, 16'h1000);
    x_in = 16'h1800; y_in = 16'h0800; target_in = 16'h1000; start = 1'b1;
    w = 0;
    while (done !== 1'b1 && w < 60) begin step(); w++; end
    t1 = cyc_cnt;
    check("b2b_first_done", {15'h0, done}, 16'h1);
    check("b2b_first_x", x_res, mx[ITER]);
    step();
    check("b2b_accept", {15'h0, busy}, 16'h1);
    w = 0;
    while (done !== 1'b1 && w < 60) begin step(); w++; end
    start = 1'b0;
    t2 = cyc_cnt;
    check("b2b_spacing", 16'(t2 - t1), 16'd18);
    check("b2b_second_y", y_res, my[ITER]);
    step(); step();
    check("b2b_stop", {15'h0, busy}, 16'h0);

    // Randomized jobs inside the legal operating range.
    for (int n = 0; n < 20; n++) begin
      rx = 16'($urandom_range(0, 2 * 16'h4DB0) - 16'h4DB0);
      ry = 16'($urandom_range(0, 2 * 16'h4DB0) - 16'h4DB0);
      rt = 16'($urandom_range(16'h0400, 16'h3FFF));
      run_job(rx, ry, rt, -1, (n < 4));
    end

    // Out-of-range target must still complete.
    run_job(16'h1000, 16'h1000, 16'hF000, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: data and angle width in bits.
REQ-002 Parameter ITER, default 16: number of CORDIC micro-rotations per job, range 1..WIDTH.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  job request; sampled only in IDLE.
REQ-006 x_in  in  WIDTH signed  initial x.
REQ-007 y_in  in  WIDTH signed  initial y.
REQ-008 target_in  in  WIDTH unsigned  target angle, 0x10000 = 360 deg; legal range 0x0400..0x3FFF.
REQ-009 x_init, y_init  out  WIDTH signed  current x/y registers, driven to the rotation ALU stage.
REQ-010 x_shift, y_shift  out  WIDTH signed  x_reg >>> i and y_reg >>> i, arithmetic shift.
REQ-011 angle, target_angle, delta_angle  out  WIDTH  accumulated angle, latched target, atan table entry for step i.
REQ-012 x_alu, y_alu, angle_alu  in  WIDTH  rotated results returned by the ALU stage in the same cycle, combinational.
REQ-013 busy  out  1  high while a job is in flight.
REQ-014 done  out  1  one-cycle pulse when results are valid.
REQ-015 x_res, y_res  out  WIDTH signed; angle_res  out  WIDTH  final results, held until the next done.

Function
REQ-016 States SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE when i==ITER-1 is consumed.
- DONE->IDLE unconditionally.
REQ-017 In IDLE with start=1, the block SHALL latch x_in->x_reg, y_in->y_reg, target_in->target_reg, 0->angle_reg and 0->i.
REQ-018 In RUN, each cycle the block SHALL load x_alu/y_alu/angle_alu into x_reg/y_reg/angle_reg and increment i; exactly ITER updates per job.
REQ-019 delta_angle SHALL be atan_lut[i], where each entry is round-to-nearest of atan(2^-i)*65536/(2*pi).
- Entries 0..3: 0x2000, 0x12E4, 0x09FB, 0x0511.
- Entries for i >= ITER are don't-care.
REQ-020 Shift amount SHALL be i, taken from the counter in the same cycle; shift is arithmetic and the sign is preserved.
REQ-021 On entry to DONE, x_res/y_res/angle_res SHALL register the final x_reg/y_reg/angle_reg, and done SHALL be high for exactly that cycle.
REQ-022 busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-023 start while busy SHALL be ignored, not queued.
REQ-024 Latency: start sampled at edge N -> done high in the cycle after edge N+ITER+1.
- Back-to-back jobs: the next start is accepted the cycle after done.
REQ-025 Arithmetic SHALL be WIDTH-bit, wrap-around, with no saturation; the caller keeps |x|,|y| <= 0x4DB0 to avoid gain overflow (gain ~1.6468).
REQ-026 target_in outside the legal range SHALL produce undefined results but SHALL NOT hang the state machine.
REQ-027 With ITER=1, the block SHALL perform one RUN cycle.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, i=0 and all registers including results to 0, with busy=0 and done=0; this applies in any state, including mid-RUN.
REQ-029 start asserted in the same cycle as rst_n=0 SHALL be discarded.

Structure
REQ-030 A shared package SHALL hold the state enum, the atan_lut constant array and WIDTH/ITER defaults.
REQ-031 The block SHALL instantiate no sub-modules; it pairs externally with the rotation ALU stage. A bench SHALL wrap both as cordic_core.

Verification
REQ-032 x=0x4000, y=0, target=0x2000 (45 deg), ITER=16 -> done after 17 cycles; x_res=y_res=0x4A87 +/-4; angle_res=0x2000 +/-2.
REQ-033 x=0x4000, y=0, target=0x1555 (30 deg) -> x_res=0x5B46 +/-4, y_res=0x34B2 +/-4.
REQ-034 start pulsed again in RUN cycle 5 -> ignored; results match the single-job run; exactly one done.
REQ-035 rst_n low in RUN cycle 8 -> next cycle IDLE, all outputs 0, and no done for the aborted job.
REQ-036 Two jobs with start held high -> second job accepted the cycle after the first done; done pulses 18 cycles apart.
REQ-037 After done with no new start -> x_res/y_res/angle_res hold stable for 100 cycles.
